repadd_multiplier: RTL and testbench
====================================

# repadd_multiplier

Sequential unsigned multiplier that computes A × B by repeated addition: P is cleared, then A is added to P while B counts down to zero. Operands arrive serially on one shared data bus under a single start handshake. The block is a Moore controller FSM driving a datapath of three registers, an adder, a decrementer and a zero detector. It is a small arithmetic slave for control logic that can tolerate a data-dependent latency of B+3 cycles.

## Interface
- WIDTH, 16, operand, counter and product width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level request; sampled only in IDLE.
- data_in  in  WIDTH  operand bus: A during LOAD_A, B during LOAD_B.
- product  out  WIDTH  P register, driven directly; reset value 0.
- done  out  1  high in DONE; reset value 0.
- busy  out  1  high in LOAD_A, LOAD_B and ADD; reset value 0.

## Operation
- Registers: A (multiplicand), B (down-counter), P (accumulator). All are WIDTH bits.
- eqz = (B == 0), combinational.
- IDLE
  - start=1 → LOAD_A; otherwise stay.
- LOAD_A
  - ld_a: A ← data_in.
  - → LOAD_B.
- LOAD_B
  - ld_b: B ← data_in.
  - clr: P ← 0.
  - → ADD.
- ADD
  - If eqz → DONE, with no register update.
  - Else P ← P + A (modulo 2^WIDTH, carry discarded) and B ← B − 1. Stay in ADD.
- DONE
  - done=1; A, B and P hold.
  - start=0 → IDLE; start=1 → stay. A held start therefore produces exactly one multiplication.
- product always shows P.
  - Intermediate sums are visible during ADD.
  - P holds its final value through DONE and IDLE until the next LOAD_B clears it.
- Outputs decode from the state register only (Moore); there is no combinational path from inputs to outputs.
- Boundary cases:
  - B=0: no additions; product=0.
  - A=0: product=0 after B add cycles.
  - Overflow wraps silently; there is no overflow flag.
  - start during LOAD_A, LOAD_B or ADD is ignored.
- rst=1 at any clock edge, including mid-operation:
  - state ← IDLE; A, B, P ← 0; done=busy=0.
  - rst has priority over every other action.

## Timing
- Edge numbering for a run:
  - e0: first edge where start=1 in IDLE.
  - e1: A is captured from data_in.
  - e2: B is captured and P is cleared.
  - e3 … e(2+B): one addition per edge.
  - e(3+B): eqz is seen; the FSM enters DONE.
- done rises after e(3+B): total latency is B+3 cycles from the sampling edge. Examples: B=1 → 4 cycles; B=0 → 3 cycles.
- The source must hold data_in stable across e1 (value A) and across e2 (value B).
- busy is high exactly from after e0 until after e(3+B).
- Minimum spacing between two back-to-back runs: DONE → IDLE requires start=0 for one edge, then a new start.

## Structure
- Package repadd_mul_pkg holds:
  - the state enum {IDLE, LOAD_A, LOAD_B, ADD, DONE};
  - the WIDTH default constant.
- Sub-module repadd_mul_datapath contains:
  - the A, B and P registers, the adder, the decrementer and eqz;
  - control inputs ld_a, ld_b, clr, add_en, dec_b.
- The controller FSM lives in the top module repadd_multiplier and drives those controls from the state.

## Test plan
- Basic run: reset, start=1 held, data_in=282 at e1, data_in=1 at e2 → product=282, done high 4 cycles after e0. Held start runs only once.
- Latency: A=5, B=3 → product steps 0,5,10,15; done after exactly 6 cycles; busy high for 6 cycles.
- Zero operands: B=0 → product=0, done after 3 cycles. Separately, A=0, B=7 → product=0.
- Overflow: A=300, B=300 → product=90000 mod 65536 = 24464.
- Reset mid-run: A=10, B=50, assert rst during ADD → next cycle state IDLE, product=0, done=0, busy=0. A subsequent 6×7 run → 42.
- Back-to-back: finish 3×4=12, deassert start for one cycle, then run 9×9 → 81. A start pulse during ADD of the first run is ignored.

Source files
------------

// File: rtl/repadd_mul_pkg.sv
// Shared types and constants for the repeated-addition multiplier.
package repadd_mul_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/repadd_mul_datapath.sv
// A/B/P registers, adder, decrementer and zero detector, steered by the controller.
module repadd_mul_datapath
  import repadd_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             clr,
  input  logic             add_en,
  input  logic             dec_b,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] product,
  output logic             eqz
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;

  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      p <= '0;
    end else begin
      if (ld_a) a <= data_in;
      if (ld_b)       b <= data_in;
      else if (dec_b) b <= b - ONE;
      // carry out of the accumulator is dropped: products wrap mod 2^WIDTH
      if (clr)         p <= '0;
      else if (add_en) p <= p + a;
    end
  end

  assign eqz     = (b == '0);
  assign product = p;

endmodule

// File: rtl/repadd_multiplier.sv
// Moore controller for the repeated-addition multiplier; latency B+3 from start.
module repadd_multiplier
  import repadd_mul_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] product,
  output logic             done,
  output logic             busy
);

  state_t state;
  state_t nxt;
  logic   ld_a, ld_b, clr, add_en, dec_b, eqz;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt    = state;
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    clr    = 1'b0;
    add_en = 1'b0;
    dec_b  = 1'b0;
    case (state)
      IDLE:   if (start) nxt = LOAD_A;
      LOAD_A: begin
        ld_a = 1'b1;
        nxt  = LOAD_B;
      end
      LOAD_B: begin
        ld_b = 1'b1;
        clr  = 1'b1;
        nxt  = ADD;
      end
      ADD: begin
        if (eqz) nxt = DONE;
        else begin
          add_en = 1'b1;
          dec_b  = 1'b1;
        end
      end
      // a held start must drop before another run can begin
      DONE:   if (!start) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign done = (state == DONE);
  assign busy = (state == LOAD_A) || (state == LOAD_B) || (state == ADD);

  repadd_mul_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .ld_a    (ld_a),
    .ld_b    (ld_b),
    .clr     (clr),
    .add_en  (add_en),
    .dec_b   (dec_b),
    .data_in (data_in),
    .product (product),
    .eqz     (eqz)
  );

endmodule

// File: tb/tb_repadd_multiplier.sv
// Directed bench for repadd_multiplier with a cycle-level reference model.
module tb_repadd_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] product;
  logic        done;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int tr[$];

  repadd_multiplier #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 running, 2 done. While running, after edge
  // e(k) with k>=2 the product is A*min(k-2,B) mod 2^16.
  int          m_mode = 0;
  int          m_n = 0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [15:0] m_p = '0;

  always @(posedge clk) begin
    int     k;
    longint prod;
    if (rst) begin
      m_mode <= 0;
      m_n    <= 0;
      m_a    <= '0;
      m_b    <= '0;
      m_p    <= '0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_mode <= 1;
          m_n    <= 0;
        end
        1: begin
          k = m_n + 1;
          m_n <= k;
          if (k == 1) m_a <= data_in;
          if (k == 2) begin
            m_b <= data_in;
            m_p <= '0;
          end
          if (k >= 3) begin
            prod = longint'(m_a) * longint'((k - 2 < int'(m_b)) ? k - 2 : int'(m_b));
            m_p <= prod[15:0];
            if (k == int'(m_b) + 3) m_mode <= 2;
          end
        end
        default: if (!start) m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_product", product, m_p);
      chk("model_done", done, m_mode == 2);
      chk("model_busy", busy, m_mode == 1);
    end
  end

  task automatic idle_cycle();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // lat counts edges after e0; done must appear at lat == B+3
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] exp_p, input int exp_lat, input bit hold);
    int lat;
    int bcnt;
    bit got;
    lat = 0; bcnt = 0; got = 1'b0;
    tr.delete();
    start = 1'b1;
    data_in = a;
    @(posedge clk); #1;
    if (busy) bcnt++;
    if (!hold) start = 1'b0;
    @(posedge clk); #1;
    lat = 1;
    if (busy) bcnt++;
    data_in = b;
    while (lat < 400 && !got) begin
      @(posedge clk); #1;
      lat++;
      tr.push_back(int'(product));
      if (busy) bcnt++;
      if (!hold && lat == 3) start = 1'b1;
      if (!hold && lat == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    chk("done_reached", got, 1);
    chk("latency", lat, exp_lat);
    chk("final_product", product, exp_p);
    chk("busy_cycles", bcnt, exp_lat);
    if (hold) begin
      repeat (3) begin
        @(posedge clk); #1;
      end
      chk("held_start_done", done, 1);
      chk("held_start_product", product, exp_p);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_product", product, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);

    run(16'd282, 16'd1, 16'd282, 4, 1'b1);
    idle_cycle();

    run(16'd5, 16'd3, 16'd15, 6, 1'b1);
    chk("step0", tr[0], 0);
    chk("step1", tr[1], 5);
    chk("step2", tr[2], 10);
    chk("step3", tr[3], 15);
    idle_cycle();

    run(16'd1234, 16'd0, 16'd0, 3, 1'b1);
    idle_cycle();
    run(16'd0, 16'd7, 16'd0, 10, 1'b1);
    idle_cycle();

    run(16'd300, 16'd300, 16'd24464, 303, 1'b1);
    idle_cycle();

    // abort a long run with reset while in ADD
    start = 1'b1;
    data_in = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    data_in = 16'd50;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrun_rst_product", product, 0);
    chk("midrun_rst_done", done, 0);
    chk("midrun_rst_busy", busy, 0);
    rst = 1'b0;
    run(16'd6, 16'd7, 16'd42, 10, 1'b1);
    idle_cycle();

    // back-to-back with a stray start pulse during ADD of the first run
    run(16'd3, 16'd4, 16'd12, 7, 1'b0);
    idle_cycle();
    chk("b2b_idle_done", done, 0);
    run(16'd9, 16'd9, 16'd81, 12, 1'b1);
    idle_cycle();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
